lfsr_seq_gen: RTL and testbench

Parametrised Fibonacci LFSR sequence generator, the next-generation replacement for the fixed 4-bit lookup-table LFSR counter. It advances on a single-cycle `tick` strobe from the 1 Hz divider or any other enable source, so it uses no derived clock. Width and taps are parameters. It adds:
- runtime seed load;
- free-run, burst and single-step modes;
- an advance counter and period-return detection;
- all-zero lock-up recovery.

---
 rtl/lfsr_seq_gen.sv | 127 ++++++++++++
 tb/tb_lfsr_seq_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_gen.sv
// Parametrised Fibonacci LFSR sequence generator with free-run, burst and
// single-step modes, runtime seed load, an advance counter, period-return
// detection and recovery from the all-zero lock-up state.
module lfsr_seq_gen #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1100),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] run_len,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic             period_hit,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FREE  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] ref_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] rem_q;
  logic             hit_q;
  logic             running_c;
  logic             advance_c;
  logic [WIDTH-1:0] lfsr_nxt_c;

  // Advance qualifier: load and stop both outrank tick on the same edge.
  assign running_c  = (state_q == S_FREE) || (state_q == S_BURST);
  assign advance_c  = tick && running_c && !load && !stop;
  // Shift in the tap parity; an all-zero state restarts from SEED.
  assign lfsr_nxt_c = (lfsr_q == '0) ? SEED
                                     : {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (mode)
              MODE_FREE:  state_d = S_FREE;
              MODE_BURST: state_d = (run_len == '0) ? S_DONE : S_BURST;
              MODE_STEP:  state_d = S_BURST;
              default:    state_d = S_IDLE;
            endcase
          end
        end
        S_FREE: begin
          if (stop) state_d = S_IDLE;
        end
        S_BURST: begin
          if (stop)                                  state_d = S_IDLE;
          else if (tick && (rem_q == CNT_W'(1)))     state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: LFSR state, reference value, counters and period pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED;
      ref_q  <= SEED;
      cnt_q  <= '0;
      rem_q  <= '0;
      hit_q  <= 1'b0;
    end else if (load) begin
      lfsr_q <= seed_in;
      ref_q  <= seed_in;
      cnt_q  <= '0;
      rem_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      hit_q <= advance_c && (lfsr_nxt_c == ref_q);
      if (advance_c) begin
        lfsr_q <= lfsr_nxt_c;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      if ((state_q == S_IDLE) && start) begin
        if (mode == MODE_BURST)     rem_q <= run_len;
        else if (mode == MODE_STEP) rem_q <= CNT_W'(1);
      end else if ((state_q == S_BURST) && advance_c) begin
        rem_q <= rem_q - CNT_W'(1);
      end
    end
  end

  assign lfsr_out   = lfsr_q;
  assign step_cnt   = cnt_q;
  assign period_hit = hit_q;
  assign busy       = running_c;
  assign done       = (state_q == S_DONE);
  assign lockup     = (lfsr_q == '0);

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Directed bench for lfsr_seq_gen: a vector table with hand-computed
// expectations, plus a counter-wrap sequence on a CNT_W=4 instance.
module tb_lfsr_seq_gen;

  logic       clk = 1'b0;
  logic       reset, tick, load, start, stop;
  logic [3:0] seed_in;
  logic [1:0] mode;
  logic [7:0] run_len;

  logic [3:0] lfsr_out;
  logic       busy, done, lockup, period_hit;
  logic [7:0] step_cnt;

  logic [3:0] w_lfsr_out;
  logic       w_busy, w_done, w_lockup, w_period_hit;
  logic [3:0] w_step_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_seq_gen dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .seed_in(seed_in),
    .mode(mode), .run_len(run_len), .start(start), .stop(stop),
    .lfsr_out(lfsr_out), .busy(busy), .done(done), .lockup(lockup),
    .period_hit(period_hit), .step_cnt(step_cnt)
  );

  lfsr_seq_gen #(.CNT_W(4)) u_wrap (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .seed_in(seed_in),
    .mode(mode), .run_len(4'(run_len)), .start(start), .stop(stop),
    .lfsr_out(w_lfsr_out), .busy(w_busy), .done(w_done), .lockup(w_lockup),
    .period_hit(w_period_hit), .step_cnt(w_step_cnt)
  );

  typedef struct {
    logic       rst, ld, st, sp, tk;
    logic [3:0] sd;
    logic [1:0] md;
    logic [7:0] rl;
    logic [3:0] q;
    logic       bz, dn, lk, ph;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] sd,
                              input logic [1:0] md, input logic [7:0] rl,
                              input logic st, input logic sp, input logic tk,
                              input logic [3:0] q, input logic bz, input logic dn,
                              input logic lk, input logic ph, input logic [7:0] cnt);
    vec_t v;
    v.rst = rst; v.ld = ld; v.sd = sd; v.md = md; v.rl = rl;
    v.st = st; v.sp = sp; v.tk = tk;
    v.q = q; v.bz = bz; v.dn = dn; v.lk = lk; v.ph = ph; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; load = v.ld; seed_in = v.sd; mode = v.md; run_len = v.rl;
    start = v.st; stop = v.sp; tick = v.tk;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; seed_in = 4'h0; mode = 2'b00; run_len = 8'h00;
    start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  logic [3:0] fseq [0:14];
  int         hits;
  int         w_hits;

  initial begin
    fseq = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
             4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000,
             4'b0001};

    //           rst ld sd    md     rl  st sp tk   q   bz dn lk ph cnt
    // Reset, then free-run over the full period.
    vecs.push_back(mk(1, 0, 4'h0, 2'b00, 8'd0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 1, 0, 1, 4'h1, 1, 0, 0, 0, 8'd0));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 0, 0, 1, fseq[i], 1, 0, 0,
                        (i == 14), 8'(i + 1)));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 0, 0, 0, 4'h1, 1, 0, 0, 0, 8'd15));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 0, 1, 0, 4'h1, 0, 0, 0, 0, 8'd15));
    // Burst of 3 from 1001.
    vecs.push_back(mk(0, 1, 4'h9, 2'b00, 8'd0, 0, 0, 0, 4'h9, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd3, 1, 0, 1, 4'h9, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h3, 1, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h6, 1, 0, 0, 0, 8'd2));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'hD, 0, 1, 0, 0, 8'd3));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'hD, 0, 0, 0, 0, 8'd3));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'hD, 0, 0, 0, 0, 8'd3));
    // Single step, then start while in DONE is ignored.
    vecs.push_back(mk(1, 0, 4'h0, 2'b00, 8'd0, 0, 0, 0, 4'h1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b10, 8'd0, 1, 0, 0, 4'h1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b10, 8'd0, 0, 0, 1, 4'h2, 0, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 1, 0, 1, 4'h2, 0, 0, 0, 0, 8'd1));
    // Reserved mode is ignored; zero-length burst finishes without advancing.
    vecs.push_back(mk(0, 0, 4'h0, 2'b11, 8'd4, 1, 0, 1, 4'h2, 0, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 1, 0, 0, 4'h2, 0, 1, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h2, 0, 0, 0, 0, 8'd1));
    // Lock-up recovery.
    vecs.push_back(mk(0, 1, 4'h0, 2'b00, 8'd0, 0, 0, 0, 4'h0, 0, 0, 1, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 1, 0, 0, 4'h0, 1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b00, 8'd0, 0, 0, 1, 4'h1, 1, 0, 0, 0, 8'd1));
    // Load beats tick and drops the FSM to IDLE.
    vecs.push_back(mk(0, 1, 4'h4, 2'b00, 8'd0, 0, 0, 1, 4'h4, 0, 0, 0, 0, 8'd0));
    // Stop mid-burst: no done, stop beats tick.
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd5, 1, 0, 0, 4'h4, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h9, 1, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 1, 1, 4'h9, 0, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h9, 0, 0, 0, 0, 8'd1));
    // Reset mid-burst.
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd5, 1, 0, 0, 4'h9, 1, 0, 0, 0, 8'd1));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h3, 1, 0, 0, 0, 8'd2));
    vecs.push_back(mk(1, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 0, 4'h0, 2'b01, 8'd0, 0, 0, 1, 4'h1, 0, 0, 0, 0, 8'd0));

    idle_inputs();
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("lfsr_out",   i, 32'(lfsr_out),   32'(vecs[i].q));
      chk("busy",       i, 32'(busy),       32'(vecs[i].bz));
      chk("done",       i, 32'(done),       32'(vecs[i].dn));
      chk("lockup",     i, 32'(lockup),     32'(vecs[i].lk));
      chk("period_hit", i, 32'(period_hit), 32'(vecs[i].ph));
      chk("step_cnt",   i, 32'(step_cnt),   32'(vecs[i].cnt));
    end

    // Counter wrap: 16 free-run advances on both instances.
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b1; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; tick = 1'b1;
    hits = 0;
    w_hits = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (period_hit) hits++;
      if (w_period_hit) w_hits++;
    end
    tick = 1'b0;
    chk("wrap_cnt",      1000, 32'(w_step_cnt), 32'd0);
    chk("wrap_lfsr",     1000, 32'(w_lfsr_out), 32'h2);
    chk("wrap_busy",     1000, 32'(w_busy),     32'd1);
    chk("wrap_lockup",   1000, 32'(w_lockup),   32'd0);
    chk("wrap_done",     1000, 32'(w_done),     32'd0);
    chk("wrap_hits",     1000, 32'(w_hits),     32'd1);
    chk("main16_cnt",    1000, 32'(step_cnt),   32'h10);
    chk("main16_lfsr",   1000, 32'(lfsr_out),   32'h2);
    chk("main16_hits",   1000, 32'(hits),       32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
